serial_pattern_generator: RTL and testbench
===========================================

// Module: serial_pattern_generator
//
// PURPOSE
// Moore-style serial pattern transmitter: the sending end of the serial bit-sequence detectors.
// On a start pulse it latches a PAT_W-bit pattern and shifts it out MSB-first, once per cycle, repeat_n times.
// Optional zero-filled gap cycles separate repeats.
// Drives detector stimulus and serial framing/sync words; out feeds a detector's `in` directly.
//
// PARAMETERS
// PAT_W    3  pattern width in bits (>=1)
// CNT_W    4  width of repeat_n / internal repeat counter
// GAP_CYC  0  idle cycles (out=0, valid=0) inserted between consecutive repeats; 0 = back-to-back
//
// PORTS
// clk       in   1        clock, rising edge
// reset     in   1        asynchronous, active-high reset
// start     in   1        request; sampled only in IDLE
// pattern   in   PAT_W    bits to send, MSB first; latched on accepted start
// repeat_n  in   CNT_W    number of pattern transmissions; latched on accepted start
// out       out  1        serial data bit (registered)
// valid     out  1        1 while out carries a pattern bit
// busy      out  1        1 in SEND and GAP
// done      out  1        one-cycle pulse after the final bit, or after a zero-count start
//
// BEHAVIOUR
// - Reset: async, clears all registers; out=0, valid=0, busy=0, done=0, state=IDLE. Takes effect immediately mid-operation; no done pulse.
// - All outputs are registered (Moore), decoded from state/shift registers.
// - States:
//   - IDLE: accepts start.
//   - SEND: shifts out pattern bits.
//   - GAP: inserts zero-filled separator cycles.
//   - DONE: asserts done for one cycle.
// - Edge E = the edge sampling start=1 in IDLE:
//   - repeat_n!=0: load shreg<=pattern, rep<=repeat_n, bitcnt<=PAT_W-1; go SEND.
//     After E: out=pattern[PAT_W-1], valid=1, busy=1.
//   - repeat_n==0: go DONE. After E: done=1, valid=0, busy=0.
// - SEND: each edge shifts shreg left; out=next MSB; bitcnt decrements.
// - Last bit of a repeat (bitcnt==0): rep decrements. Next state:
//   - rep==1: DONE.
//   - rep>1 and GAP_CYC==0: reload shreg from the latched pattern copy, stay SEND.
//     No bubble: the next repeat's MSB follows the previous LSB on the next cycle.
//   - rep>1 and GAP_CYC>0: GAP.
// - GAP: GAP_CYC cycles with out=0, valid=0, busy=1; then reload, SEND.
// - DONE: exactly one cycle; done=1, out=0, valid=0, busy=0; then IDLE.
// - start ignored in SEND, GAP and DONE (not queued). pattern/repeat_n changes during busy have no effect.
// - Latency:
//   - First bit appears 1 cycle after start.
//   - Total transmission: repeat_n*PAT_W + (repeat_n-1)*GAP_CYC cycles.
//   - done follows 1 cycle after the last bit.
// - Counter rep is CNT_W bits; max repeats = 2^CNT_W-1, no wrap.
//
// TESTING
// 1 pattern=3'b110, repeat_n=1 -> out 1,1,0 with valid=1 on cycles 1-3 after start; done=1 on cycle 4 only; busy low from cycle 4.
// 2 pattern=110, repeat_n=3, GAP_CYC=0, out looped into the "110" Moore detector -> out=110110110 (9 contiguous valid cycles); detector out pulses exactly 3 times.
// 3 repeat_n=0, start=1 -> done=1 on next cycle only; valid and busy never assert; out stays 0.
// 4 start re-pulsed during SEND with a different pattern -> ignored; original bit stream and single done unchanged.
// 5 reset asserted mid-SEND (after 2nd bit) -> out/valid/busy drop to 0 immediately, no done pulse; a fresh start afterwards transmits the full pattern from the MSB.
// 6 GAP_CYC=2, pattern=101, repeat_n=2 -> out 1,0,1,0,0,1,0,1; valid 1,1,1,0,0,1,1,1; done on the following cycle.

Source files
------------

// File: rtl/serial_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_generator
// Purpose  : Moore serial pattern transmitter. On an accepted start the
//            module latches a PAT_W-bit pattern and a repeat count. It then
//            shifts the pattern out MSB-first, repeat_n times. Repeats can be
//            separated by GAP_CYC zero-filled idle cycles.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_generator #(
    parameter int PAT_W   = 3,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    // Bit counter holds PAT_W-1 down to 0; gap counter holds GAP_CYC-1 down to 0.
    localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [BIT_W-1:0] C_BIT_ONE  = BIT_W'(1);
    localparam logic [GAP_W-1:0] C_GAP_ONE  = GAP_W'(1);
    localparam logic [CNT_W-1:0] C_REP_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] pat_q,   pat_d;
    logic [CNT_W-1:0] rep_q,   rep_d;
    logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
    logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
    logic             out_q,   out_d;
    logic             valid_q, valid_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [PAT_W-1:0] w_shifted;

    // The shift register always holds the bit currently on out in its MSB.
    assign w_shifted = shreg_q << 1;

    // State, datapath and registered outputs; reset acts immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            pat_q    <= '0;
            rep_q    <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            out_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            pat_q    <= pat_d;
            rep_q    <= rep_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. Output next values are decoded from the destination
    // state so that the outputs stay registered and glitch-free.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        pat_d    = pat_q;
        rep_d    = rep_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        out_d    = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (repeat_n != '0) begin
                        pat_d    = pattern;
                        shreg_d  = pattern;
                        rep_d    = repeat_n;
                        bitcnt_d = C_BIT_LAST;
                        state_d  = S_SEND;
                        out_d    = pattern[PAT_W-1];
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        // A zero count produces only the completion pulse.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_SEND: begin
                if (bitcnt_q != '0) begin
                    shreg_d  = w_shifted;
                    bitcnt_d = bitcnt_q - C_BIT_ONE;
                    out_d    = w_shifted[PAT_W-1];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    rep_d = rep_q - C_REP_ONE;
                    if (rep_q == C_REP_ONE) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (GAP_CYC == 0) begin
                        // Back-to-back: next repeat's MSB directly follows the LSB.
                        shreg_d  = pat_q;
                        bitcnt_d = C_BIT_LAST;
                        out_d    = pat_q[PAT_W-1];
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        state_d  = S_GAP;
                        gapcnt_d = C_GAP_LOAD;
                        busy_d   = 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (gapcnt_q == '0) begin
                    state_d  = S_SEND;
                    shreg_d  = pat_q;
                    bitcnt_d = C_BIT_LAST;
                    out_d    = pat_q[PAT_W-1];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    gapcnt_d = gapcnt_q - C_GAP_ONE;
                    busy_d   = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_generator
// Purpose  : Directed bench for serial_pattern_generator. It uses one
//            back-to-back instance (GAP_CYC=0) and one gapped instance
//            (GAP_CYC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_generator;

    logic       clk;
    logic       reset;

    logic       start0, start1;
    logic [2:0] pattern0, pattern1;
    logic [3:0] repeat0, repeat1;
    logic       out0, valid0, busy0, done0;
    logic       out1, valid1, busy1, done1;

    int n_vec;
    int n_err;

    serial_pattern_generator #(.PAT_W(3), .CNT_W(4), .GAP_CYC(0)) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .start    (start0),
        .pattern  (pattern0),
        .repeat_n (repeat0),
        .out      (out0),
        .valid    (valid0),
        .busy     (busy0),
        .done     (done0)
    );

    serial_pattern_generator #(.PAT_W(3), .CNT_W(4), .GAP_CYC(2)) u_dut1 (
        .clk      (clk),
        .reset    (reset),
        .start    (start1),
        .pattern  (pattern1),
        .repeat_n (repeat1),
        .out      (out1),
        .valid    (valid1),
        .busy     (busy1),
        .done     (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset = 1'b1;
        step();
        step();
        got = {out0, valid0, busy0, done0};
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL reset dut0 {out,valid,busy,done}: got %b expected 0000", got);
        end
        n_vec++;
        got = {out1, valid1, busy1, done1};
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL reset dut1 {out,valid,busy,done}: got %b expected 0000", got);
        end
        n_vec++;
        reset = 1'b0;
        step();
    endtask

    // Single transmission of 110: bits on cycles 1-3, done on cycle 4 only.
    task automatic test_single();
        logic [3:0] exp_v [1:5];
        logic [3:0] got;
        exp_v[1] = 4'b1110; exp_v[2] = 4'b1110; exp_v[3] = 4'b0110;
        exp_v[4] = 4'b0001; exp_v[5] = 4'b0000;
        pattern0 = 3'b110;
        repeat0  = 4'd1;
        start0   = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            start0 = 1'b0;
            got = {out0, valid0, busy0, done0};
            if (got !== exp_v[i]) begin
                n_err++;
                $display("FAIL single c%0d {out,valid,busy,done}: got %b expected %b", i, got, exp_v[i]);
            end
            n_vec++;
        end
    endtask

    // Three back-to-back repeats of 110 feeding a bench-side 110 detector.
    task automatic test_back_to_back();
        logic [2:0] pat;
        logic [2:0] win;
        logic [3:0] got, exp_v;
        int         det;
        pat = 3'b110;
        win = 3'b000;
        det = 0;
        pattern0 = 3'b110;
        repeat0  = 4'd3;
        start0   = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            start0 = 1'b0;
            if (i <= 9)       exp_v = {pat[2 - ((i - 1) % 3)], 3'b110};
            else if (i == 10) exp_v = 4'b0001;
            else              exp_v = 4'b0000;
            got = {out0, valid0, busy0, done0};
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL b2b c%0d {out,valid,busy,done}: got %b expected %b", i, got, exp_v);
            end
            n_vec++;
            if (valid0 === 1'b1) begin
                win = {win[1:0], out0};
                if (win == 3'b110) det++;
            end
        end
        if (det != 3) begin
            n_err++;
            $display("FAIL b2b detector hits: got %0d expected 3", det);
        end
        n_vec++;
    endtask

    // Zero repeat count: a lone done pulse, no valid or busy.
    task automatic test_zero_count();
        logic [3:0] got, exp_v;
        pattern0 = 3'b111;
        repeat0  = 4'd0;
        start0   = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            start0 = 1'b0;
            exp_v = (i == 1) ? 4'b0001 : 4'b0000;
            got = {out0, valid0, busy0, done0};
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL zero c%0d {out,valid,busy,done}: got %b expected %b", i, got, exp_v);
            end
            n_vec++;
        end
    endtask

    // Restart during SEND and input changes while busy are ignored.
    task automatic test_start_ignored();
        logic [2:0] pat;
        logic [3:0] got, exp_v;
        pat = 3'b110;
        pattern0 = 3'b110;
        repeat0  = 4'd2;
        for (int i = 1; i <= 9; i++) begin
            start0 = (i == 1) || (i == 3);
            if (i == 3) begin
                pattern0 = 3'b001;
                repeat0  = 4'd4;
            end
            step();
            if (i <= 6)      exp_v = {pat[2 - ((i - 1) % 3)], 3'b110};
            else if (i == 7) exp_v = 4'b0001;
            else             exp_v = 4'b0000;
            got = {out0, valid0, busy0, done0};
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL ignore c%0d {out,valid,busy,done}: got %b expected %b", i, got, exp_v);
            end
            n_vec++;
        end
        start0 = 1'b0;
    endtask

    // Reset mid-SEND clears outputs at once and gives no done pulse.
    // A fresh start afterwards sends the whole pattern again.
    task automatic test_reset_mid_send();
        logic [3:0] got;
        logic [3:0] exp_v [1:4];
        exp_v[1] = 4'b1110; exp_v[2] = 4'b1110; exp_v[3] = 4'b0110; exp_v[4] = 4'b0001;
        pattern0 = 3'b110;
        repeat0  = 4'd1;
        start0   = 1'b1;
        step();
        start0 = 1'b0;
        step();
        got = {out0, valid0, busy0, done0};
        if (got !== 4'b1110) begin
            n_err++;
            $display("FAIL rstmid bit2 {out,valid,busy,done}: got %b expected 1110", got);
        end
        n_vec++;
        reset = 1'b1;
        #1;
        got = {out0, valid0, busy0, done0};
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid immediate {out,valid,busy,done}: got %b expected 0000", got);
        end
        n_vec++;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            step();
            got = {out0, valid0, busy0, done0};
            if (got !== 4'b0000) begin
                n_err++;
                $display("FAIL rstmid after c%0d {out,valid,busy,done}: got %b expected 0000", i, got);
            end
            n_vec++;
        end
        start0 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            start0 = 1'b0;
            got = {out0, valid0, busy0, done0};
            if (got !== exp_v[i]) begin
                n_err++;
                $display("FAIL rstmid restart c%0d {out,valid,busy,done}: got %b expected %b", i, got, exp_v[i]);
            end
            n_vec++;
        end
    endtask

    // GAP_CYC=2 with pattern 101 sent twice: 101, two gap cycles, then 101.
    task automatic test_gap();
        logic [7:0] eo, ev;
        logic [3:0] got, exp_v;
        eo = 8'b10100101;
        ev = 8'b11100111;
        pattern1 = 3'b101;
        repeat1  = 4'd2;
        start1   = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            start1 = 1'b0;
            if (i <= 8)      exp_v = {eo[8 - i], ev[8 - i], 2'b10};
            else if (i == 9) exp_v = 4'b0001;
            else             exp_v = 4'b0000;
            got = {out1, valid1, busy1, done1};
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL gap c%0d {out,valid,busy,done}: got %b expected %b", i, got, exp_v);
            end
            n_vec++;
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        pattern0 = 3'b000;
        pattern1 = 3'b000;
        repeat0  = 4'd0;
        repeat1  = 4'd0;

        test_reset();
        test_single();
        test_back_to_back();
        test_zero_count();
        test_start_ignored();
        test_reset_mid_send();
        test_gap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
